nios_oci_debug_mem: RTL
=======================

# nios_oci_debug_mem

On-chip debug memory and monitor-register sequencer for the Nios II JTAG debug path. It consumes the system-clock command strobes and the 38-bit `jdo` payload produced by the JTAG debug module's system-clock side. It executes address loads, reads and writes against a private word-addressed RAM, and returns `MonDReg`, `monitor_ready` and `monitor_error` to the JTAG debug module wrapper, which shifts them back to the host.

## Interface
- `ADDR_W`, default 8: debug RAM word-address width; depth is 2^ADDR_W 32-bit words; legal range 4..16.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `jdo`  in  38  command payload, valid in any cycle where a strobe is high.
- `take_action_ocimem_a`  in  1  address-load command strobe (one-cycle pulse).
- `take_action_ocimem_b`  in  1  write command strobe.
- `take_no_action_ocimem_a`  in  1  streaming-read command strobe.
- `MonDReg`  out  32  last read data.
- `monitor_ready`  out  1  high when `MonDReg` holds the result of the most recent read.
- `monitor_error`  out  1  sticky error flag for a dropped command.
- `MonAReg`  out  ADDR_W  current word address, for status and debug.

## Operation
- Payload fields:
  - address = `jdo[ADDR_W+1:2]` (byte address, word-aligned);
  - `jdo[34]` = read-after-load;
  - `jdo[33]` = clear error;
  - write data = `jdo[31:0]`.
- FSM states are IDLE, RD1 and RD2. Commands are accepted only in IDLE.
- **ocimem_a in IDLE**
  - `MonAReg` <= address.
  - If `jdo[33]` is set, `monitor_error` <= 0.
  - If `jdo[34]` is set: start a read at the new address, go to RD1, and set `monitor_ready` <= 0. The address is not incremented.
  - Otherwise, stay in IDLE.
- **ocimem_b in IDLE**
  - RAM[`MonAReg`] <= `jdo[31:0]`.
  - `MonAReg` <= `MonAReg`+1.
  - `monitor_ready` is unchanged. Stay in IDLE.
- **no_action_ocimem_a in IDLE**
  - Start a read at `MonAReg`, go to RD1, set `monitor_ready` <= 0.
  - `MonAReg` <= `MonAReg`+1.
- **RD1:** RAM synchronous read, address registered. Go to RD2.
- **RD2:** RAM output is valid. `MonDReg` <= q, `monitor_ready` <= 1, go to IDLE.
- **Strobe priority:** ocimem_a > ocimem_b > no_action_ocimem_a.
  - More than one strobe in the same cycle: only the highest executes, and `monitor_error` <= 1.
- **Any strobe in RD1 or RD2:** the command is dropped, `monitor_error` <= 1, and the read in flight completes normally.
  - Exception: ocimem_a with `jdo[33]` set still clears nothing while busy; the error is still set.
- **Address wrap:** `MonAReg` increments modulo 2^ADDR_W; all-ones wraps to 0.
- **Read-after-write:** a read started in the cycle after a write to the same address returns the new data.
- RAM contents are not reset; they are undefined after power-up.

## Timing
- **Reset values** (when `reset_n` = 0 at an edge):
  - `MonDReg` = 0, `monitor_ready` = 0, `monitor_error` = 0, `MonAReg` = 0, state = IDLE.
  - Reset takes effect at that edge, including mid-read: the pending read is abandoned and `MonDReg` is not updated.
- **Read latency:** a strobe sampled at edge k moves the FSM to RD1. `MonDReg` and `monitor_ready` = 1 are visible after edge k+2.
  - `monitor_ready` is 0 after edge k until edge k+2.
  - The earliest next accepted command is at edge k+3 (first IDLE cycle).
- **Write latency:** a write at edge k updates the RAM at edge k. `MonAReg` shows +1 after edge k. Back-to-back writes are accepted every cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset mid-read:** issue a read, assert `reset_n` = 0 during RD1 -> after the edge, all outputs are 0, state is IDLE, and a fresh read works normally.
- **Load, write, read-back:**
  - ocimem_a with address 0x010, `jdo[34]` = 0 -> `MonAReg` = 4.
  - ocimem_b with 0xDEADBEEF, then 0x12345678 on consecutive cycles -> `MonAReg` = 6.
  - ocimem_a with address 0x010, `jdo[34]` = 1 -> 2 cycles later `MonDReg` = 0xDEADBEEF, `monitor_ready` = 1, `MonAReg` = 4.
  - no_action -> `MonDReg` = 0xDEADBEEF (address 4), `MonAReg` = 5.
  - no_action -> `MonDReg` = 0x12345678 (address 5), `MonAReg` = 6.
- **Wrap (ADDR_W = 8):** load address 0x3FC, write 0xA5A5A5A5 -> `MonAReg` = 0. Load 0x3FC with read -> `MonDReg` = 0xA5A5A5A5.
- **Busy drop:** no_action read, then ocimem_b with 0xFFFFFFFF one cycle later -> `monitor_error` = 1, RAM unchanged, `MonDReg` = the original data. Then ocimem_a with `jdo[33]` = 1 in IDLE -> `monitor_error` = 0.
- **Simultaneous strobes:** ocimem_a (address 0x020) and ocimem_b in the same cycle -> `MonAReg` = 8, no write occurs, `monitor_error` = 1.
- **Read-after-write:** write 0x0000CAFE at address 7, then load address 0x01C with read on the very next cycle -> `MonDReg` = 0x0000CAFE.

Source files
------------

// File: rtl/nios_oci_debug_mem.sv
// nios_oci_debug_mem
//   On-chip debug RAM plus monitor-register sequencer for the Nios II JTAG
//   debug path. System-clock command strobes carry a 38-bit jdo payload that
//   loads the word address, writes the RAM, or starts a read. Read data is
//   returned in MonDReg with a ready flag; dropped commands raise a sticky
//   error flag.
//
// Ports
//   clk                      system clock, rising edge
//   reset_n                  synchronous active-low reset
//   jdo[37:0]                command payload, valid while a strobe is high
//   take_action_ocimem_a     address load (jdo[34] read-after-load, jdo[33] clear error)
//   take_action_ocimem_b     write jdo[31:0] at MonAReg, then increment
//   take_no_action_ocimem_a  read at MonAReg, then increment
//   MonDReg[31:0]            last read data
//   monitor_ready            MonDReg holds the result of the most recent read
//   monitor_error            sticky dropped-command flag
//   MonAReg[ADDR_W-1:0]      current word address
module nios_oci_debug_mem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] MonAReg
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD1  = 2'd1,
        S_RD2  = 2'd2
    } state_t;

    state_t            r_state;
    logic [31:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_rd_addr_p0;
    logic [31:0]       r_q_p1;

    logic              w_idle;
    logic              w_any;
    logic              w_multi;
    logic              w_ld;
    logic              w_ld_rd;
    logic              w_wr;
    logic              w_rd_stream;
    logic              w_rd_start;
    logic [ADDR_W-1:0] w_addr;
    logic              w_unused_jdo;

    // Commands are only acted on out of reset and in IDLE; gating with
    // reset_n keeps a strobe coincident with reset from touching the RAM.
    assign w_idle      = reset_n && (r_state == S_IDLE);
    assign w_any       = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_multi     = (take_action_ocimem_a & take_action_ocimem_b)
                       | (take_action_ocimem_a & take_no_action_ocimem_a)
                       | (take_action_ocimem_b & take_no_action_ocimem_a);
    assign w_addr      = jdo[ADDR_W+1:2];

    // Priority: address load > write > streaming read.
    assign w_ld        = w_idle & take_action_ocimem_a;
    assign w_ld_rd     = w_ld & jdo[34];
    assign w_wr        = w_idle & ~take_action_ocimem_a & take_action_ocimem_b;
    assign w_rd_stream = w_idle & ~take_action_ocimem_a & ~take_action_ocimem_b
                       & take_no_action_ocimem_a;
    assign w_rd_start  = w_ld_rd | w_rd_stream;

    assign w_unused_jdo = ^{jdo[37:35], jdo[32]};

    // Control: FSM, address register, status flags and returned data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            MonAReg       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ld) begin
                        MonAReg <= w_addr;
                        if (w_ld_rd) begin
                            r_state       <= S_RD1;
                            monitor_ready <= 1'b0;
                        end
                    end else if (w_wr) begin
                        MonAReg <= MonAReg + 1'b1;
                    end else if (w_rd_stream) begin
                        MonAReg       <= MonAReg + 1'b1;
                        r_state       <= S_RD1;
                        monitor_ready <= 1'b0;
                    end
                    // A collision error wins over a clear carried by the same load.
                    if (w_multi) begin
                        monitor_error <= 1'b1;
                    end else if (w_ld && jdo[33]) begin
                        monitor_error <= 1'b0;
                    end
                end
                S_RD1: begin
                    r_state <= S_RD2;
                    if (w_any) monitor_error <= 1'b1;
                end
                S_RD2: begin
                    MonDReg       <= r_q_p1;
                    monitor_ready <= 1'b1;
                    r_state       <= S_IDLE;
                    if (w_any) monitor_error <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // p0: read address captured with the accepting strobe.
    // p1: synchronous RAM read, consumed by the control block in RD2.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[MonAReg] <= jdo[31:0];
        end
        if (w_rd_start) begin
            r_rd_addr_p0 <= w_ld ? w_addr : MonAReg;
        end
        r_q_p1 <= r_mem[r_rd_addr_p0];
    end

endmodule
